// File: rtl/vp_instr_sequencer.sv
// In-order instruction sequencer: FIFO-buffered host instructions, one issue per
// cycle, with MUL_GAP bubbles after each MUL. Define VP_SEQ_STATS_EN for issue/bubble counters.
module vp_instr_sequencer #(
   parameter int DEPTH   = 8,
   parameter int MUL_GAP = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [12:0]                in_instr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       hold,
   input  logic                       flush,
   output logic [12:0]                out_instr,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
`ifdef VP_SEQ_STATS_EN
   ,
   output logic [15:0]                issued_cnt,
   output logic [15:0]                bubble_cnt
`endif
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      gap_cnt, gap_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic [PW-1:0]   wptr, rptr;
   logic [12:0]     mem [DEPTH];
   logic            push, pop;

   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready && !flush;
   assign busy     = (count != '0) || out_valid || (gap_cnt != 4'd0);

   // gap and occupancy for the next cycle; flush overrides push and issue
   always_comb begin
      gap_nxt = gap_cnt;
      cnt_nxt = count;
      if (flush) begin
         gap_nxt = 4'd0;
         cnt_nxt = '0;
      end else begin
         if (gap_cnt != 4'd0)
            gap_nxt = gap_cnt - 4'd1;
         if (pop && (mem[rptr][12:11] == 2'b11))
            gap_nxt = 4'(MUL_GAP);
         case ({push, pop})
            2'b10:   cnt_nxt = count + CW'(1);
            2'b01:   cnt_nxt = count - CW'(1);
            default: cnt_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = IDLE;
      if (gap_nxt != 4'd0)     state_nxt = GAP;
      else if (cnt_nxt != '0)  state_nxt = ISSUE;
   end

   always_comb pop = (state == ISSUE) && !hold && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         gap_cnt   <= 4'd0;
         wptr      <= '0;
         rptr      <= '0;
         out_instr <= 13'h0000;
         out_valid <= 1'b0;
      end else begin
         count     <= cnt_nxt;
         gap_cnt   <= gap_nxt;
         out_valid <= pop;
         if (pop)
            out_instr <= mem[rptr];
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
         end
      end
   end

   // storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk)
      if (push) mem[wptr] <= in_instr;

`ifdef VP_SEQ_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issued_cnt <= 16'h0000;
         bubble_cnt <= 16'h0000;
      end else begin
         if (pop)          issued_cnt <= issued_cnt + 16'd1;
         if (state == GAP) bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vp_instr_sequencer.sv
// Bench for vp_instr_sequencer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vp_instr_sequencer;
   localparam int DEPTH   = 8;
   localparam int MUL_GAP = 2;
   localparam int CW      = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [12:0]   in_instr = 13'h0;
   logic          in_valid = 1'b0;
   logic          hold = 1'b0;
   logic          flush = 1'b0;
   logic          in_ready, out_valid, busy;
   logic [12:0]   out_instr;
   logic [CW-1:0] count;
`ifdef VP_SEQ_STATS_EN
   logic [15:0]   issued_cnt, bubble_cnt;
`endif

   vp_instr_sequencer #(.DEPTH(DEPTH), .MUL_GAP(MUL_GAP)) dut (
      .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
      .in_ready(in_ready), .hold(hold), .flush(flush), .out_instr(out_instr),
      .out_valid(out_valid), .count(count), .busy(busy)
`ifdef VP_SEQ_STATS_EN
      , .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 0;
   int maxc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: queue of pending instructions, remaining bubble count, last issue
   logic [12:0] mq[$];
   int          mgap = 0;
   logic        mvalid = 1'b0;
   logic [12:0] minstr = 13'h0;
   bit          m_iss, m_psh;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete(); mgap = 0; mvalid = 1'b0; minstr = 13'h0;
      end else if (flush) begin
         mq.delete(); mgap = 0; mvalid = 1'b0;
      end else begin
         m_iss = (mq.size() > 0) && (mgap == 0) && !hold;
         m_psh = in_valid && (mq.size() < DEPTH);
         if (mgap > 0) mgap--;
         mvalid = m_iss;
         if (m_iss) begin
            minstr = mq.pop_front();
            if (minstr[12:11] == 2'b11) mgap = MUL_GAP;
         end
         if (m_psh) mq.push_back(in_instr);
      end
   end

   always @(negedge clk) if (chk_en) begin
      chk("in_ready",  in_ready,  32'(mq.size() < DEPTH));
      chk("count",     count,     mq.size());
      chk("out_valid", out_valid, mvalid);
      chk("out_instr", out_instr, minstr);
      chk("busy",      busy,      32'((mq.size() != 0) || mvalid || (mgap != 0)));
   end

   // issue log seen at the DUT output, for directed ordering/timing checks
   logic [12:0] lg_i[$];
   int          lg_c[$];
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         lg_i.push_back(out_instr);
         lg_c.push_back(cyc);
      end
      if (int'(count) > maxc) maxc = int'(count);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push_one(input logic [12:0] d, output int acc);
      int n;
      n = 0;
      in_valid = 1'b1; in_instr = d;
      while (in_ready !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL push_timeout: in_ready stuck low, instr %0h", d);
      end
      step();
      acc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic clr_log();
      lg_i.delete(); lg_c.delete();
   endtask

   initial begin
      int acc, a0, c0;
      logic [12:0] e1 [4];
      logic [12:0] e2 [3];

      e1 = '{13'h0001, 13'h0200, 13'h0511, 13'h0621};
      e2 = '{13'h1000, 13'h1800, 13'h0E01};

      repeat (3) step();
      chk_en = 1;
      reset = 1'b1;
      step();
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 13'h0000);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);

      // back-to-back non-MUL stream
      clr_log(); maxc = 0;
      push_one(e1[0], a0);
      for (int i = 1; i < 4; i++) push_one(e1[i], acc);
      repeat (4) step();
      chk("t1_n_issued", lg_i.size(), 4);
      for (int i = 0; i < 4 && i < lg_i.size(); i++) begin
         chk("t1_instr", lg_i[i], e1[i]);
         chk("t1_cycle", lg_c[i], a0 + 1 + i);
      end
      chk("t1_max_count", maxc, 1);
      chk("t1_busy_end", busy, 0);

      // MUL bubbles
      clr_log();
      push_one(e2[0], a0);
      for (int i = 1; i < 3; i++) push_one(e2[i], acc);
      repeat (6) step();
      chk("t2_n_issued", lg_i.size(), 3);
      if (lg_i.size() == 3) begin
         c0 = lg_c[0];
         for (int i = 0; i < 3; i++) chk("t2_instr", lg_i[i], e2[i]);
         chk("t2_first_cycle", c0, a0 + 1);
         chk("t2_mul_cycle", lg_c[1], c0 + 1);
         chk("t2_after_gap", lg_c[2], c0 + 1 + MUL_GAP + 1);
      end

      // fill under hold, 9th waits, then drain across the pointer wrap
      hold = 1'b1;
      for (int i = 1; i <= 8; i++) push_one(13'(i), acc);
      chk("t3_full_ready", in_ready, 0);
      chk("t3_full_count", count, 8);
      clr_log();
      hold = 1'b0;
      push_one(13'h0009, acc);
      repeat (12) step();
      chk("t3_n_issued", lg_i.size(), 9);
      if (lg_i.size() == 9)
         for (int i = 0; i < 9; i++) begin
            chk("t3_instr", lg_i[i], 13'(i + 1));
            chk("t3_cycle", lg_c[i], lg_c[0] + i);
         end

      // flush with a concurrent push
      hold = 1'b1;
      for (int i = 0; i < 5; i++) push_one(13'h00A0 + 13'(i), acc);
      chk("t4_count_5", count, 5);
      in_valid = 1'b1; in_instr = 13'h1800; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("t4_count", count, 0);
      chk("t4_out_valid", out_valid, 0);
      clr_log();
      hold = 1'b0;
      repeat (10) step();
      chk("t4_no_issue", lg_i.size(), 0);

      // asynchronous reset mid-gap with 3 entries queued
      hold = 1'b1;
      push_one(13'h1800, acc);
      for (int i = 1; i <= 3; i++) push_one(13'h0100 + 13'(i), acc);
      clr_log();
      hold = 1'b0;
      step();
      chk("t5_mul_valid", out_valid, 1);
      chk("t5_mul_instr", out_instr, 13'h1800);
      chk("t5_mul_count", count, 3);
      #2 reset = 1'b0;
      #1;
      chk("t5_async_valid", out_valid, 0);
      chk("t5_async_instr", out_instr, 13'h0000);
      chk("t5_async_count", count, 0);
      chk("t5_async_ready", in_ready, 1);
      chk("t5_async_busy", busy, 0);
      step();
      reset = 1'b1;
      clr_log();
      repeat (10) step();
      chk("t5_no_stale", lg_i.size(), 0);

`ifdef VP_SEQ_STATS_EN
      reset = 1'b0; step(); reset = 1'b1;
      push_one(13'h0001, acc);
      push_one(13'h1800, acc);
      push_one(13'h1000, acc);
      repeat (8) step();
      chk("s_issued", issued_cnt, 3);
      chk("s_bubble", bubble_cnt, 2);
      flush = 1'b1; step(); flush = 1'b0;
      chk("s_issued_flush", issued_cnt, 3);
      chk("s_bubble_flush", bubble_cnt, 2);
`endif

      // randomized traffic, occasional flush and async reset pulses
      for (int i = 0; i < 3000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_instr = 13'($urandom);
         hold     = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         step();
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            #1 reset = 1'b1;
         end
      end
      in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
      repeat (40) step();
      chk("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vp_instr_sequencer.md
# vp_instr_sequencer

Instruction sequencer that sits directly upstream of the vector processor and drives its 13-bit instruction input. Host-supplied instructions enter through a valid/ready handshake and are buffered in a FIFO. They are issued to the processor one per cycle, in order. After every MUL the sequencer inserts a configurable number of bubble cycles so the multi-cycle vector multiply completes before the next instruction is presented.

## Interface

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2
- MUL_GAP, 2, bubble cycles inserted after each issued MUL (0..15)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_instr  input  13  instruction {opcode[12:11], reg[10:9], addr[8:0]}; opcodes: 00 LOAD, 01 STORE, 10 ADD, 11 MUL
- in_valid  input  1  in_instr valid
- in_ready  output  1  FIFO can accept; combinational, equals (count < DEPTH)
- hold  input  1  suppresses issue while high; FIFO still accepts
- flush  input  1  synchronous clear of FIFO and gap counter
- out_instr  output  13  registered instruction to processor
- out_valid  output  1  registered; high for exactly the cycles in which out_instr is a new instruction
- count  output  $clog2(DEPTH+1)  current FIFO occupancy
- busy  output  1  high when count != 0, out_valid is high, or the gap counter != 0

## Operation

- Push: when in_valid && in_ready at an edge, in_instr is written at the tail and count increments.
  - When count == DEPTH, in_ready is low and in_valid is ignored; nothing is written or lost silently, and the host must hold the instruction.
- FSM states:
  - IDLE: FIFO empty, gap counter 0.
  - ISSUE: FIFO non-empty and gap counter 0.
  - GAP: gap counter != 0.
- Issue condition at an edge: state ISSUE and hold == 0. The head is popped into out_instr, out_valid is set to 1, and count decrements.
  - If push and issue happen in the same edge, count is unchanged.
- If the issued opcode == 2'b11 and MUL_GAP != 0, the gap counter loads MUL_GAP and the FSM enters GAP.
- In GAP, the counter decrements once per cycle regardless of hold. When it reaches 0, the FSM returns to ISSUE or IDLE.
- When no issue occurs at an edge, out_valid = 0 and out_instr holds its previous value.
- Flush (sampled at an edge, takes priority over push and issue):
  - count = 0, read/write pointers = 0, gap counter = 0, out_valid = 0 next cycle.
  - A push requested in the flush cycle is discarded.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Reset (asynchronous, any time including mid-GAP or mid-burst):
  - out_instr = 13'h0000, out_valid = 0, count = 0, gap counter = 0, FSM = IDLE, in_ready = 1.
  - FIFO contents are discarded.

## Timing

- Latency: an instruction accepted at edge N into an empty, idle, non-held FIFO appears on out_instr with out_valid = 1 after edge N+1.
- Throughput: one issue per cycle for back-to-back non-MUL instructions.
- A MUL issued at edge k blocks issue until edge k+MUL_GAP+1. With MUL_GAP = 0 there are no bubbles.
- Deasserting hold at edge k allows an issue at edge k+1, provided hold is sampled low at that edge.
- in_ready rises in the cycle after a pop from full.

## Configuration

- VP_SEQ_STATS_EN defined: adds output issued_cnt (16 bits).
  - Increments on every issue and wraps 16'hFFFF -> 0.
  - Cleared by reset; not cleared by flush.
  - Also adds output bubble_cnt (16 bits), which increments each cycle spent in GAP, with the same wrap, reset and flush rules.
- VP_SEQ_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan

- Reset, then push 13'h0001, 13'h0200, 13'h0511, 13'h0621 on consecutive cycles.
  - out_valid is high for 4 consecutive cycles, starting one cycle after the first accept, with the instructions in that order.
  - count peaks at 1; busy falls after the last issue.
- MUL_GAP = 2, push 13'h1000, 13'h1800, 13'h0E01 back-to-back.
  - ADD and MUL issue on consecutive cycles, followed by 2 cycles of out_valid = 0, then 13'h0E01 issues.
- hold = 1, push 9 instructions (13'h0001 to 13'h0009).
  - in_ready drops after 8 accepts and count = 8; the 9th is held.
  - Release hold: all 9 issue in order, one per cycle, and the pointers wrap correctly.
- Fill with 5 entries, assert flush for 1 cycle while also pushing 13'h1800.
  - Next cycle: count = 0, out_valid = 0, and 13'h1800 is never issued.
- Assert reset low mid-GAP after a MUL, with 3 entries queued.
  - Outputs go to 0 immediately (asynchronously), count = 0, in_ready = 1.
  - After release, no stale instruction issues.
- With VP_SEQ_STATS_EN, MUL_GAP = 2: issue 13'h0001, 13'h1800, 13'h1000 → issued_cnt = 3, bubble_cnt = 2; flush leaves both unchanged.
